ifu_axi_rd_responder: RTL and testbench
=======================================

// Module: ifu_axi_rd_responder
// PURPOSE
//  AXI4 read-channel responder (slave side) for IFU instruction-fetch traffic.
//  Accepts AR requests (arvalid/arready) from the IFU initiator and returns R beats.
//  Beat data comes from a synchronous instruction memory with fixed 1-cycle read latency.
//  Sits between the swerv core's IFU AXI port and the instruction memory macro.
// PARAMETERS
//  ADDR_W    32   AXI address width (byte address)
//  DATA_W    64   AXI/memory data width; beat size is DATA_W/8 bytes
//  ID_W       3   AXI ID width
//  MEM_AW    12   memory word-address width; valid words are 0 .. 2**MEM_AW-1
// PORTS
//  clk              in   1        clock; all logic on the rising edge
//  rst_l            in   1        asynchronous active-low reset
//  ifu_axi_arvalid  in   1        read-address valid
//  ifu_axi_arready  out  1        read-address ready
//  ifu_axi_araddr   in   ADDR_W   start byte address
//  ifu_axi_arid     in   ID_W     transaction ID
//  ifu_axi_arlen    in   8        beats minus 1
//  ifu_axi_arburst  in   2        burst type: 01=INCR, 10=WRAP
//  ifu_axi_rvalid   out  1        read-data valid
//  ifu_axi_rready   in   1        read-data ready
//  ifu_axi_rdata    out  DATA_W   beat data
//  ifu_axi_rid      out  ID_W     echoed arid
//  ifu_axi_rresp    out  2        00=OKAY, 10=SLVERR
//  ifu_axi_rlast    out  1        final beat of burst
//  mem_re           out  1        memory read enable
//  mem_addr         out  MEM_AW   memory word address
//  mem_rdata        in   DATA_W   valid the cycle after mem_re
// BEHAVIOUR
//  Reset: arready=1, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, mem_re=0, mem_addr=0;
//    FSM=IDLE. Reset asserted mid-burst discards the burst; no further beats are returned.
//  One outstanding burst: arready=1 only in IDLE. AR handshake = arvalid&arready.
//  FSM: IDLE -(AR hs)-> FETCH -> RESP -(R hs, not last)-> FETCH | -(R hs, last)-> IDLE.
//  On AR hs, latch arid, arlen, word address = araddr[MEM_AW+log2(DATA_W/8)-1:log2(DATA_W/8)],
//    and the error flag. Low byte-offset bits of araddr are ignored.
//  Error flag=1 when: arburst not 01/10; araddr above the memory range; any INCR beat
//    beyond the last word; or WRAP with arlen not in {1,3,7,15}.
//  FETCH: mem_re=1 for exactly one cycle with mem_addr=current word. Skipped when the
//    error flag is set; next state RESP.
//  RESP: rvalid=1; rdata=mem_rdata captured into a register the cycle after mem_re
//    (0 on error); rid=latched ID; rresp=10 on error else 00; rlast=(beat==arlen).
//  rvalid, rdata, rid, rresp and rlast hold stable while rvalid&!rready (AXI stability).
//  Latency: AR hs at cycle T -> mem_re at T+1 -> first rvalid at T+2.
//    Subsequent beats: rvalid at R hs + 2 (one bubble cycle). Throughput is 1 beat per 2 cycles.
//  Address advance: INCR word+1. WRAP: word = (word & ~(arlen)) | ((word+1) & arlen);
//    the wrap boundary is (arlen+1) beats.
//  Error bursts return all arlen+1 beats with SLVERR and the last beat carries rlast.
//  Beat counter is 8 bits; arlen=255 gives 256 beats, and the counter does not overflow
//    before rlast.
//  An AR presented while busy waits with arready=0. Its payload is not sampled.
// TESTING
//  1) Reset: rst_l=0 -> arready=1, rvalid=0. Release rst_l -> still arready=1, rvalid=0.
//  2) INCR single beat: araddr=0x40, arlen=0, arid=5, mem[8]=0xA5 -> one beat,
//     rdata=0xA5, rid=5, rresp=00, rlast=1, rvalid at T+2.
//  3) INCR 4 beats at word 10 with rready toggling 1/0 -> words 10..13 in order,
//     data held stable during stalls, rlast only on beat 4, arready=0 until the last hs.
//  4) WRAP arlen=3 at word 6 -> words 6,7,4,5; rlast on 5.
//  5) Errors: araddr=word 4095 INCR arlen=1 -> 2 beats, rresp=10, rdata=0, mem_re never high.
//     arburst=00 -> 1 beat SLVERR.
//  6) Async rst_l pulse during beat 2 of 8 -> rvalid=0 immediately, arready=1.
//     A new AR after release completes normally.

Source files
------------

// File: rtl/ifu_axi_rd_responder_if.sv
// AXI4 read-address / read-data channel bundle between the IFU initiator and its read responder.
interface ifu_axi_rd_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 3
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arid, arlen, arburst, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arburst, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/ifu_axi_rd_responder.sv
// AXI4 read responder for IFU fetch traffic: one outstanding INCR/WRAP burst, served beat by beat
// from a synchronous instruction memory with one cycle of read latency.
module ifu_axi_rd_responder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 3,
  parameter int unsigned MEM_AW = 12
) (
  input  logic                  clk,
  input  logic                  rst_l,
  ifu_axi_rd_responder_if.slave ifu_axi,
  output logic                  mem_re,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned BOFF = $clog2(DATA_W / 8);
  localparam int unsigned SW   = ((MEM_AW > 8) ? MEM_AW : 8) + 1;
  localparam logic [SW-1:0] LAST_WORD = SW'((64'd1 << MEM_AW) - 64'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [1:0]        rresp_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              first_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic [MEM_AW-1:0] word_q;
  logic              wrap_q;
  logic              err_q;

  logic              ar_hs_c;
  logic [MEM_AW-1:0] ar_word_c;
  logic [SW-1:0]     ar_end_c;
  logic              ar_err_c;
  logic [MEM_AW-1:0] wrap_mask_c;
  logic [MEM_AW-1:0] word_inc_c;
  logic [MEM_AW-1:0] word_next_c;
  logic              last_beat_c;
  logic              unused_boff;

  assign ar_hs_c     = ifu_axi.arvalid & arready_q;
  assign ar_word_c   = ifu_axi.araddr[MEM_AW+BOFF-1:BOFF];
  assign ar_end_c    = SW'(ar_word_c) + SW'(ifu_axi.arlen);
  assign unused_boff = ^ifu_axi.araddr[BOFF-1:0];

  // Request legality: burst type, address range, INCR overrun, WRAP length
  always_comb begin
    ar_err_c = 1'b0;
    case (ifu_axi.arburst)
      2'b01:   ar_err_c = (ar_end_c > LAST_WORD);
      2'b10:   ar_err_c = !(ifu_axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15});
      default: ar_err_c = 1'b1;
    endcase
    if (|ifu_axi.araddr[ADDR_W-1:MEM_AW+BOFF]) ar_err_c = 1'b1;
  end

  // WRAP keeps the bits above arlen and lets the low bits roll over
  assign wrap_mask_c = MEM_AW'(len_q);
  assign word_inc_c  = word_q + MEM_AW'(1);
  assign word_next_c = wrap_q ? ((word_q & ~wrap_mask_c) | (word_inc_c & wrap_mask_c))
                              : word_inc_c;
  assign last_beat_c = (beat_q == len_q);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      rdata_q   <= '0;
      first_q   <= 1'b0;
      len_q     <= '0;
      beat_q    <= '0;
      word_q    <= '0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs_c) begin
            arready_q <= 1'b0;
            rid_q     <= ifu_axi.arid;
            len_q     <= ifu_axi.arlen;
            wrap_q    <= (ifu_axi.arburst == 2'b10);
            err_q     <= ar_err_c;
            word_q    <= ar_word_c;
            beat_q    <= '0;
            mem_re    <= !ar_err_c;
            if (!ar_err_c) mem_addr <= ar_word_c;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          mem_re   <= 1'b0;
          rvalid_q <= 1'b1;
          rresp_q  <= err_q ? 2'b10 : 2'b00;
          rlast_q  <= last_beat_c;
          first_q  <= !err_q;
          if (err_q) rdata_q <= '0;
          state_q  <= RESP;
        end
        RESP: begin
          // Memory output is only guaranteed on the first RESP cycle; keep a copy for stalls
          if (first_q) begin
            rdata_q <= mem_rdata;
            first_q <= 1'b0;
          end
          if (ifu_axi.rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (last_beat_c) begin
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              beat_q  <= beat_q + 8'd1;
              word_q  <= word_next_c;
              mem_re  <= !err_q;
              if (!err_q) mem_addr <= word_next_c;
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifu_axi.arready = arready_q;
  assign ifu_axi.rvalid  = rvalid_q;
  assign ifu_axi.rlast   = rlast_q;
  assign ifu_axi.rresp   = rresp_q;
  assign ifu_axi.rid     = rid_q;
  assign ifu_axi.rdata   = first_q ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_ifu_axi_rd_responder.sv
// Directed self-checking bench for ifu_axi_rd_responder with a behavioural 1-cycle instruction memory.
module tb_ifu_axi_rd_responder;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned MEM_AW = 12;
  localparam logic [63:0] BASE   = 64'h1000_0000_0000_0000;

  logic              clk = 1'b0;
  logic              rst_l = 1'b0;
  logic              mem_re;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] mem [0:4095];
  int                n_checks = 0;
  int                n_pass = 0;
  int                mem_re_cnt = 0;
  int                snap;

  always #5 clk = ~clk;

  ifu_axi_rd_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) ifu_axi ();

  ifu_axi_rd_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_AW(MEM_AW)
  ) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .ifu_axi  (ifu_axi),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata  <= mem[mem_addr];
      mem_re_cnt <= mem_re_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [2:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic exp_re, input logic [11:0] exp_maddr);
    check("ar_ready_idle", 64'(ifu_axi.arready), 64'd1);
    ifu_axi.arvalid = 1'b1;
    ifu_axi.araddr  = addr;
    ifu_axi.arid    = id;
    ifu_axi.arlen   = len;
    ifu_axi.arburst = burst;
    tick();
    ifu_axi.arvalid = 1'b0;
    ifu_axi.araddr  = 32'hFFFF_FFF8;
    ifu_axi.arid    = 3'd0;
    ifu_axi.arlen   = 8'd0;
    ifu_axi.arburst = 2'b11;
    check("ar_ready_busy", 64'(ifu_axi.arready), 64'd0);
    check("mem_re", 64'(mem_re), 64'(exp_re));
    if (exp_re) check("mem_addr", 64'(mem_addr), 64'(exp_maddr));
  endtask

  task automatic get_beat(input string tag, input int stall, input logic [63:0] exp_data,
                          input logic [1:0] exp_resp, input logic exp_last, input logic [2:0] exp_id);
    int waits = 0;
    while (!ifu_axi.rvalid && waits < 20) begin
      tick();
      waits++;
    end
    check({tag, "_lat"}, 64'(waits), 64'd1);
    check({tag, "_data"}, ifu_axi.rdata, exp_data);
    check({tag, "_resp"}, 64'(ifu_axi.rresp), 64'(exp_resp));
    check({tag, "_last"}, 64'(ifu_axi.rlast), 64'(exp_last));
    check({tag, "_id"}, 64'(ifu_axi.rid), 64'(exp_id));
    check({tag, "_arready"}, 64'(ifu_axi.arready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_v"}, 64'(ifu_axi.rvalid), 64'd1);
      check({tag, "_hold_d"}, ifu_axi.rdata, exp_data);
      check({tag, "_hold_l"}, 64'(ifu_axi.rlast), 64'(exp_last));
    end
    ifu_axi.rready = 1'b1;
    tick();
    ifu_axi.rready = 1'b0;
    check({tag, "_bubble"}, 64'(ifu_axi.rvalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    for (int i = 0; i < 4096; i++) mem[i] = BASE | 64'(i);
    mem[8] = 64'hA5;
    ifu_axi.arvalid = 1'b0;
    ifu_axi.araddr  = '0;
    ifu_axi.arid    = '0;
    ifu_axi.arlen   = '0;
    ifu_axi.arburst = 2'b01;
    ifu_axi.rready  = 1'b0;

    // Reset state
    #12;
    check("rst_arready", 64'(ifu_axi.arready), 64'd1);
    check("rst_rvalid", 64'(ifu_axi.rvalid), 64'd0);
    check("rst_rlast", 64'(ifu_axi.rlast), 64'd0);
    check("rst_rresp", 64'(ifu_axi.rresp), 64'd0);
    check("rst_rid", 64'(ifu_axi.rid), 64'd0);
    check("rst_rdata", ifu_axi.rdata, 64'd0);
    check("rst_mem_re", 64'(mem_re), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    check("post_rst_arready", 64'(ifu_axi.arready), 64'd1);
    check("post_rst_rvalid", 64'(ifu_axi.rvalid), 64'd0);

    // INCR single beat
    ar_send(32'h40, 3'd5, 8'd0, 2'b01, 1'b1, 12'd8);
    get_beat("single", 0, 64'hA5, 2'b00, 1'b1, 3'd5);
    check("single_arready", 64'(ifu_axi.arready), 64'd1);

    // INCR 4 beats with stalls
    ar_send(32'h50, 3'd2, 8'd3, 2'b01, 1'b1, 12'd10);
    get_beat("incr0", 0, 64'h1000_0000_0000_000A, 2'b00, 1'b0, 3'd2);
    get_beat("incr1", 1, 64'h1000_0000_0000_000B, 2'b00, 1'b0, 3'd2);
    get_beat("incr2", 0, 64'h1000_0000_0000_000C, 2'b00, 1'b0, 3'd2);
    get_beat("incr3", 2, 64'h1000_0000_0000_000D, 2'b00, 1'b1, 3'd2);
    check("incr_arready", 64'(ifu_axi.arready), 64'd1);

    // WRAP 4 beats starting at word 6
    ar_send(32'h30, 3'd1, 8'd3, 2'b10, 1'b1, 12'd6);
    get_beat("wrap0", 0, 64'h1000_0000_0000_0006, 2'b00, 1'b0, 3'd1);
    get_beat("wrap1", 0, 64'h1000_0000_0000_0007, 2'b00, 1'b0, 3'd1);
    get_beat("wrap2", 1, 64'h1000_0000_0000_0004, 2'b00, 1'b0, 3'd1);
    get_beat("wrap3", 0, 64'h1000_0000_0000_0005, 2'b00, 1'b1, 3'd1);

    // Error bursts never touch memory
    snap = mem_re_cnt;
    ar_send(32'h7FF8, 3'd3, 8'd1, 2'b01, 1'b0, 12'd0);
    get_beat("err_ovr0", 1, 64'd0, 2'b10, 1'b0, 3'd3);
    get_beat("err_ovr1", 0, 64'd0, 2'b10, 1'b1, 3'd3);
    ar_send(32'h40, 3'd4, 8'd0, 2'b00, 1'b0, 12'd0);
    get_beat("err_burst", 0, 64'd0, 2'b10, 1'b1, 3'd4);
    ar_send(32'h0, 3'd6, 8'd2, 2'b10, 1'b0, 12'd0);
    get_beat("err_wlen0", 0, 64'd0, 2'b10, 1'b0, 3'd6);
    get_beat("err_wlen1", 0, 64'd0, 2'b10, 1'b0, 3'd6);
    get_beat("err_wlen2", 0, 64'd0, 2'b10, 1'b1, 3'd6);
    ar_send(32'h8000, 3'd7, 8'd0, 2'b01, 1'b0, 12'd0);
    get_beat("err_range", 0, 64'd0, 2'b10, 1'b1, 3'd7);
    check("err_no_mem_re", 64'(mem_re_cnt - snap), 64'd0);

    // Async reset during beat 2 of 8
    ar_send(32'hA0, 3'd6, 8'd7, 2'b01, 1'b1, 12'd20);
    get_beat("rst_b0", 0, 64'h1000_0000_0000_0014, 2'b00, 1'b0, 3'd6);
    w = 0;
    while (!ifu_axi.rvalid && w < 20) begin
      tick();
      w++;
    end
    check("rst_b1_valid", 64'(ifu_axi.rvalid), 64'd1);
    check("rst_b1_data", ifu_axi.rdata, 64'h1000_0000_0000_0015);
    #2 rst_l = 1'b0;
    #1;
    check("midrst_rvalid", 64'(ifu_axi.rvalid), 64'd0);
    check("midrst_arready", 64'(ifu_axi.arready), 64'd1);
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    tick();
    check("after_rst_rvalid", 64'(ifu_axi.rvalid), 64'd0);
    check("after_rst_mem_re", 64'(mem_re), 64'd0);
    ar_send(32'h18, 3'd2, 8'd0, 2'b01, 1'b1, 12'd3);
    get_beat("post_rst", 0, 64'h1000_0000_0000_0003, 2'b00, 1'b1, 3'd2);
    check("post_rst_done", 64'(ifu_axi.arready), 64'd1);

    // Longest INCR burst: 256 beats from word 0
    ar_send(32'h0, 3'd4, 8'd255, 2'b01, 1'b1, 12'd0);
    for (int i = 0; i < 256; i++) begin
      get_beat("long", 0, (i == 8) ? 64'hA5 : (BASE | 64'(i)), 2'b00, (i == 255), 3'd4);
    end
    check("long_arready", 64'(ifu_axi.arready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
